// File: rtl/res_pack_pkg.sv
// Shared constants and FSM encoding for the result-image packer.
package res_pack_pkg;

  localparam int IMG_W     = 128;
  localparam int N_PIX     = 16384;
  localparam int N_WORD    = 1024;
  localparam int WORD_BITS = 16;

  localparam int PIX_AW  = 14;
  localparam int WORD_AW = 10;
  localparam int BIT_CW  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/res_pack_shreg.sv
// Thresholds one pixel per cycle into an MSB-first 16-bit word; flags the
// cycle in which the 16th pixel of a word arrives.
module res_pack_shreg
  import res_pack_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 shift_en,
  input  logic [7:0]           pix,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word
);

  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [BIT_CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                 pix_bit;

  // word is the value the register takes this edge, so the top can latch a
  // completed word in the same edge the last pixel is captured
  always_comb begin
    pix_bit    = (pix >= THRESH);
    word       = {shift_q[WORD_BITS-2:0], pix_bit};
    word_valid = shift_en && (bit_cnt_q == BIT_CW'(WORD_BITS - 1));
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    if (clear) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (shift_en) begin
      shift_d   = word;
      bit_cnt_d = bit_cnt_q + BIT_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/res_pack.sv
// Streams the 128x128 result RAM, thresholds each pixel and writes the
// bit-packed image into the 1024x16 packed RAM.
module res_pack
  import res_pack_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 res_rd,
  output logic [PIX_AW-1:0]    res_addr,
  input  logic [7:0]           res_di,
  output logic                 sti_wr,
  output logic [WORD_AW-1:0]   sti_addr,
  output logic [WORD_BITS-1:0] sti_do,
  output logic                 busy,
  output logic                 done
);

  localparam logic [PIX_AW-1:0]  PIX_LAST  = PIX_AW'(N_PIX - 1);
  localparam logic [WORD_AW-1:0] WORD_LAST = WORD_AW'(N_WORD - 1);

  state_e               state_q, state_d;
  logic                 res_rd_q, res_rd_d;
  logic [PIX_AW-1:0]    res_addr_q, res_addr_d;
  logic                 sti_wr_q, sti_wr_d;
  logic [WORD_AW-1:0]   sti_addr_q, sti_addr_d;
  logic [WORD_BITS-1:0] sti_do_q, sti_do_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [WORD_AW-1:0]   word_cnt_q, word_cnt_d;

  logic                 shreg_clear;
  logic                 word_valid;
  logic [WORD_BITS-1:0] word;

  res_pack_shreg #(.THRESH(THRESH)) u_shreg (
    .clk        (clk),
    .reset      (reset),
    .clear      (shreg_clear),
    .shift_en   (pix_valid_q),
    .pix        (res_di),
    .word_valid (word_valid),
    .word       (word)
  );

  // pix_valid tracks the one-cycle RAM read latency
  always_comb begin
    state_d     = state_q;
    res_rd_d    = res_rd_q;
    res_addr_d  = res_addr_q;
    sti_wr_d    = 1'b0;
    sti_addr_d  = sti_addr_q;
    sti_do_d    = sti_do_q;
    done_d      = done_q;
    pix_valid_d = res_rd_q;
    word_cnt_d  = word_cnt_q;
    shreg_clear = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = READ;
          res_rd_d    = 1'b1;
          res_addr_d  = '0;
          word_cnt_d  = '0;
          done_d      = 1'b0;
          shreg_clear = 1'b1;
        end
      end
      READ: begin
        if (res_addr_q == PIX_LAST) begin
          state_d  = FLUSH;
          res_rd_d = 1'b0;
        end else begin
          res_addr_d = res_addr_q + PIX_AW'(1);
        end
      end
      FLUSH: begin
        if (sti_wr_q && (sti_addr_q == WORD_LAST)) begin
          state_d    = DONE;
          done_d     = 1'b1;
          res_addr_d = '0;
          sti_addr_d = '0;
          sti_do_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_valid) begin
      sti_wr_d   = 1'b1;
      sti_addr_d = word_cnt_q;
      sti_do_d   = word;
      if (word_cnt_q != WORD_LAST) begin
        word_cnt_d = word_cnt_q + WORD_AW'(1);
      end
    end

    busy_d = (state_d == READ) || (state_d == FLUSH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      res_rd_q    <= 1'b0;
      res_addr_q  <= '0;
      sti_wr_q    <= 1'b0;
      sti_addr_q  <= '0;
      sti_do_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      res_rd_q    <= res_rd_d;
      res_addr_q  <= res_addr_d;
      sti_wr_q    <= sti_wr_d;
      sti_addr_q  <= sti_addr_d;
      sti_do_q    <= sti_do_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_valid_q <= pix_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign res_rd   = res_rd_q;
  assign res_addr = res_addr_q;
  assign sti_wr   = sti_wr_q;
  assign sti_addr = sti_addr_q;
  assign sti_do   = sti_do_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_res_pack.sv
// Bench for res_pack: two instances (THRESH 1 and 10) share one behavioural
// result RAM; written words are compared with a per-pixel packing model.
module tb_res_pack;
  import res_pack_pkg::*;

  typedef struct {
    int          pat;
    bit          sel;
    bit          glitch;
    int          widx;
    logic [15:0] exp_word;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start10;
  logic        sel;

  logic        rd1, wr1, busy1, done1;
  logic [13:0] addr1;
  logic [9:0]  waddr1;
  logic [15:0] do1;
  logic [7:0]  di1;

  logic        rd10, wr10, busy10, done10;
  logic [13:0] addr10;
  logic [9:0]  waddr10;
  logic [15:0] do10;
  logic [7:0]  di10;

  logic        m_rd, m_wr, m_busy, m_done;
  logic [13:0] m_addr;
  logic [9:0]  m_waddr;
  logic [15:0] m_do;

  logic [7:0]  mem   [N_PIX];
  logic [15:0] got   [N_WORD];
  logic [15:0] expw  [N_WORD];
  logic [15:0] orig  [N_WORD];

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  res_pack dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .res_rd(rd1), .res_addr(addr1), .res_di(di1),
    .sti_wr(wr1), .sti_addr(waddr1), .sti_do(do1),
    .busy(busy1), .done(done1)
  );

  res_pack #(.THRESH(8'd10)) dut10 (
    .clk(clk), .reset(reset), .start(start10),
    .res_rd(rd10), .res_addr(addr10), .res_di(di10),
    .sti_wr(wr10), .sti_addr(waddr10), .sti_do(do10),
    .busy(busy10), .done(done10)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read RAM: data for the address seen this cycle appears next cycle
  always @(posedge clk) begin
    di1  <= mem[addr1];
    di10 <= mem[addr10];
  end

  assign m_rd    = sel ? rd10    : rd1;
  assign m_wr    = sel ? wr10    : wr1;
  assign m_busy  = sel ? busy10  : busy1;
  assign m_done  = sel ? done10  : done1;
  assign m_addr  = sel ? addr10  : addr1;
  assign m_waddr = sel ? waddr10 : waddr1;
  assign m_do    = sel ? do10    : do1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
  endtask

  function automatic int activity1();
    return int'(rd1) + int'(wr1) + int'(busy1) + int'(done1) +
           int'(addr1 != 0) + int'(waddr1 != 0) + int'(do1 != 0);
  endfunction

  function automatic int activity10();
    return int'(rd10) + int'(wr10) + int'(busy10) + int'(done10) +
           int'(addr10 != 0) + int'(waddr10 != 0) + int'(do10 != 0);
  endfunction

  // expected packed image straight from the pixel->word/bit mapping rule
  task automatic computeModel(input logic [7:0] thr);
    for (int k = 0; k < N_WORD; k++) expw[k] = 16'h0000;
    for (int p = 0; p < N_PIX; p++)
      if (mem[p] >= thr) expw[p / 16][15 - (p % 16)] = 1'b1;
  endtask

  task automatic loadPattern(input int pat);
    logic [15:0] w;
    for (int p = 0; p < N_PIX; p++) mem[p] = 8'd0;
    case (pat)
      1: begin
        for (int p = 0; p < N_PIX; p++) mem[p] = 8'($urandom_range(0, 20));
        for (int p = 16; p < 32; p++) mem[p] = 8'd0;
        mem[16] = 8'd9;
        mem[17] = 8'd10;
        mem[5]  = 8'd255;
      end
      2: begin
        for (int p = 0; p < N_PIX; p++)
          if ((((p / IMG_W) + (p % IMG_W)) & 1) == 1) mem[p] = 8'($urandom_range(1, 255));
      end
      3: begin
        for (int k = 0; k < N_WORD; k++) orig[k] = 16'($urandom);
        orig[0] = 16'h8001;
        for (int p = 0; p < N_PIX; p++) begin
          w = orig[p >> 4];
          if (w[15 - (p & 15)]) mem[p] = 8'($urandom_range(1, 255));
        end
        mem[0]  = 8'd1;
        mem[15] = 8'd200;
      end
      4: begin
        mem[0]  = 8'd1;
        mem[15] = 8'd200;
      end
      default: ;
    endcase
  endtask

  // one full pass on the selected instance, timing measured from the start edge S
  task automatic applyStimulus(input bit which, input bit glitch);
    int s, rd_n, rd_bad, wr_n, wr_bad, last_wr, done_at, flag_bad, idle_bad, mism;
    rd_n = 0; rd_bad = 0; wr_n = 0; wr_bad = 0; last_wr = -1;
    done_at = -1; flag_bad = 0; idle_bad = 0; mism = 0;
    for (int k = 0; k < N_WORD; k++) got[k] = ~expw[k];
    sel = which;
    @(negedge clk);
    if (which) start10 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    start1 = 1'b0;
    start10 = 1'b0;
    for (int i = 0; i < 16392; i++) begin
      @(negedge clk);
      if (glitch && cyc == s + 99) begin
        if (which) start10 = 1'b1; else start1 = 1'b1;
      end
      if (glitch && cyc == s + 100) begin
        start1 = 1'b0;
        start10 = 1'b0;
      end
      if (m_rd) begin
        if (cyc != s + rd_n || m_addr != 14'(rd_n)) rd_bad++;
        rd_n++;
      end
      if (m_wr) begin
        if (m_waddr != 10'(wr_n)) wr_bad++;
        got[m_waddr] = m_do;
        last_wr = cyc;
        wr_n++;
      end
      if (m_done && done_at < 0) done_at = cyc;
      if (m_busy != (cyc <= s + 16385)) flag_bad++;
      if (m_done != (cyc >= s + 16386)) flag_bad++;
      if (!m_busy && (m_rd || m_wr || m_addr != 0 || m_waddr != 0 || m_do != 0)) idle_bad++;
    end
    for (int k = 0; k < N_WORD; k++) if (got[k] !== expw[k]) mism++;
    checkOutput("read_count", rd_n, N_PIX);
    checkOutput("read_seq_errors", rd_bad, 0);
    checkOutput("write_count", wr_n, N_WORD);
    checkOutput("write_order_errors", wr_bad, 0);
    checkOutput("last_write_offset", last_wr - s, 16385);
    checkOutput("done_offset", done_at - s, 16386);
    checkOutput("busy_done_errors", flag_bad, 0);
    checkOutput("idle_hold_errors", idle_bad, 0);
    checkOutput("word_mismatches", mism, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int cur_pat, s, act, mism;
    string nm;

    vecs[0] = '{pat: 0, sel: 1'b0, glitch: 1'b1, widx: 0,    exp_word: 16'h0000};
    vecs[1] = '{pat: 0, sel: 1'b0, glitch: 1'b1, widx: 1023, exp_word: 16'h0000};
    vecs[2] = '{pat: 1, sel: 1'b1, glitch: 1'b0, widx: 1,    exp_word: 16'h4000};
    vecs[3] = '{pat: 2, sel: 1'b0, glitch: 1'b0, widx: 0,    exp_word: 16'h5555};
    vecs[4] = '{pat: 2, sel: 1'b0, glitch: 1'b0, widx: 8,    exp_word: 16'hAAAA};
    vecs[5] = '{pat: 2, sel: 1'b0, glitch: 1'b0, widx: 1023, exp_word: 16'hAAAA};
    vecs[6] = '{pat: 2, sel: 1'b0, glitch: 1'b0, widx: 16,   exp_word: 16'h5555};
    vecs[7] = '{pat: 3, sel: 1'b0, glitch: 1'b0, widx: 0,    exp_word: 16'h8001};

    reset = 1'b0;
    start1 = 1'b0;
    start10 = 1'b0;
    sel = 1'b0;
    for (int p = 0; p < N_PIX; p++) mem[p] = 8'd0;

    #2;
    checkOutput("reset_outputs", activity1() + activity10(), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    act = 0;
    repeat (6) begin
      @(negedge clk);
      act += activity1() + activity10();
    end
    checkOutput("no_access_before_start", act, 0);

    cur_pat = -1;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pat != cur_pat) begin
        loadPattern(vecs[i].pat);
        computeModel(vecs[i].sel ? 8'd10 : 8'd1);
        applyStimulus(vecs[i].sel, vecs[i].glitch);
        cur_pat = vecs[i].pat;
        if (cur_pat == 3) begin
          mism = 0;
          for (int k = 0; k < N_WORD; k++) if (got[k] !== orig[k]) mism++;
          checkOutput("roundtrip_mismatches", mism, 0);
        end
      end
      nm = $sformatf("vec%0d_word%0d", i, vecs[i].widx);
      checkOutput(nm, got[vecs[i].widx], vecs[i].exp_word);
    end

    // reset partway through a pass, then a fresh pass must run from scratch
    loadPattern(4);
    sel = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    start1 = 1'b0;
    while (cyc < s + 4999) @(negedge clk);
    checkOutput("midpass_busy", busy1, 1);
    checkOutput("midpass_addr", addr1, 4999);
    reset = 1'b0;
    #1;
    checkOutput("async_reset_outputs", activity1(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      act += activity1();
    end
    checkOutput("no_resume_after_reset", act, 0);

    computeModel(8'd1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("sparse_word0", got[0], 16'h8001);
    checkOutput("sparse_word1", got[1], 16'h0000);
    checkOutput("sparse_word1023", got[1023], 16'h0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
